// File: rtl/energy_budget_dvfs_ctrl_pkg.sv
// Shared types and constants for the energy-budget DVFS governor:
// frequency table, FSM state encoding and level width.
package power_pkg;

  localparam int unsigned LEVEL_W  = 3;
  localparam int unsigned NUM_FREQ = 5;

  localparam logic [15:0] FREQ_TABLE [0:NUM_FREQ-1] = '{
    16'd200, 16'd400, 16'd600, 16'd800, 16'd1000
  };

  typedef enum logic [2:0] {
    IDLE,
    MEASURE,
    EVAL,
    REQ,
    SETTLE
  } state_t;

  // Out-of-table levels clamp to the fastest entry.
  function automatic logic [15:0] freq_of(input logic [LEVEL_W-1:0] lvl);
    if (int'(lvl) < NUM_FREQ) return FREQ_TABLE[lvl];
    return FREQ_TABLE[NUM_FREQ-1];
  endfunction

endpackage

// File: rtl/energy_budget_dvfs_ctrl_sampler.sv
// Energy window sampler: holds the window-start snapshot and cycle counter,
// and reports the (modulo 2^64) energy consumed since the snapshot.
module energy_window_sampler (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        count,
  input  logic [31:0] window_cycles,
  input  logic [63:0] energy_total_pj,
  output logic        window_done,
  output logic [63:0] delta
);

  logic [63:0] snap_q, snap_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] last_cnt;

  // A zero-length window behaves as a one-cycle window.
  assign last_cnt    = (window_cycles == '0) ? '0 : window_cycles - 32'd1;
  assign window_done = (cnt_q == last_cnt);
  assign delta       = energy_total_pj - snap_q;

  always_comb begin
    snap_d = snap_q;
    cnt_d  = cnt_q;
    if (load) begin
      snap_d = energy_total_pj;
      cnt_d  = '0;
    end else if (count) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q <= '0;
      cnt_q  <= '0;
    end else begin
      snap_q <= snap_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/energy_budget_dvfs_ctrl.sv
// Windowed energy-budget governor: compares per-window energy against a
// budget and steps the frequency level through a req/ack handshake.
module energy_budget_dvfs_ctrl
  import power_pkg::*;
#(
  parameter int unsigned NUM_LEVELS    = 5,
  parameter int unsigned RESET_LEVEL   = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOW_SHIFT     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] window_cycles,
  input  logic [63:0] budget_pj,
  input  logic [63:0] energy_total_pj,
  output logic        freq_req,
  output logic [15:0] freq_req_mhz,
  input  logic        freq_ack,
  output logic [15:0] current_freq_mhz,
  output logic [2:0]  level,
  output logic        over_budget,
  output logic [63:0] window_energy_pj,
  output logic [31:0] window_count
);

  localparam logic [LEVEL_W-1:0] TOP_LEVEL   = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LEVEL_W-1:0] RST_LEVEL   = LEVEL_W'(RESET_LEVEL);
  localparam logic [15:0]        SETTLE_LAST = (SETTLE_CYCLES == 0) ? '0 : 16'(SETTLE_CYCLES - 1);

  state_t              state_q, state_d;
  logic                freq_req_q, freq_req_d;
  logic [15:0]         freq_req_mhz_q, freq_req_mhz_d;
  logic [15:0]         cur_freq_q, cur_freq_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [LEVEL_W-1:0]  target_q, target_d;
  logic                over_q, over_d;
  logic [63:0]         win_energy_q, win_energy_d;
  logic [31:0]         win_count_q, win_count_d;
  logic [15:0]         settle_q, settle_d;

  logic                samp_load, samp_count, window_done;
  logic [63:0]         delta, low_thresh;
  logic                step_down, step_up;
  logic [LEVEL_W-1:0]  eval_target;

  energy_window_sampler u_sampler (
    .clk             (clk),
    .reset           (reset),
    .load            (samp_load),
    .count           (samp_count),
    .window_cycles   (window_cycles),
    .energy_total_pj (energy_total_pj),
    .window_done     (window_done),
    .delta           (delta)
  );

  // Hysteresis band: hold while delta lies in [budget - budget>>LOW_SHIFT, budget].
  always_comb begin
    low_thresh  = budget_pj - (budget_pj >> LOW_SHIFT);
    step_down   = (delta > budget_pj);
    step_up     = !step_down && (delta < low_thresh);
    eval_target = level_q;
    if (step_down && level_q != '0)
      eval_target = level_q - 1'b1;
    else if (step_up && level_q != TOP_LEVEL)
      eval_target = level_q + 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    freq_req_d     = freq_req_q;
    freq_req_mhz_d = freq_req_mhz_q;
    cur_freq_d     = cur_freq_q;
    level_d        = level_q;
    target_d       = target_q;
    over_d         = 1'b0;
    win_energy_d   = win_energy_q;
    win_count_d    = win_count_q;
    settle_d       = settle_q;
    samp_load      = 1'b0;
    samp_count     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          samp_load = 1'b1;
          state_d   = MEASURE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          samp_count = 1'b1;
          if (window_done) state_d = EVAL;
        end
      end
      EVAL: begin
        win_energy_d = delta;
        win_count_d  = win_count_q + 32'd1;
        over_d       = step_down;
        if (eval_target != level_q) begin
          target_d       = eval_target;
          freq_req_mhz_d = freq_of(eval_target);
          freq_req_d     = 1'b1;
          state_d        = REQ;
        end else begin
          samp_load = 1'b1;
          state_d   = enable ? MEASURE : IDLE;
        end
      end
      REQ: begin
        if (freq_ack) begin
          freq_req_d = 1'b0;
          level_d    = target_q;
          cur_freq_d = freq_of(target_q);
          settle_d   = '0;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          samp_load = 1'b1;
          state_d   = enable ? MEASURE : IDLE;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      freq_req_q     <= 1'b0;
      freq_req_mhz_q <= freq_of(RST_LEVEL);
      cur_freq_q     <= freq_of(RST_LEVEL);
      level_q        <= RST_LEVEL;
      target_q       <= RST_LEVEL;
      over_q         <= 1'b0;
      win_energy_q   <= '0;
      win_count_q    <= '0;
      settle_q       <= '0;
    end else begin
      state_q        <= state_d;
      freq_req_q     <= freq_req_d;
      freq_req_mhz_q <= freq_req_mhz_d;
      cur_freq_q     <= cur_freq_d;
      level_q        <= level_d;
      target_q       <= target_d;
      over_q         <= over_d;
      win_energy_q   <= win_energy_d;
      win_count_q    <= win_count_d;
      settle_q       <= settle_d;
    end
  end

  assign freq_req         = freq_req_q;
  assign freq_req_mhz     = freq_req_mhz_q;
  assign current_freq_mhz = cur_freq_q;
  assign level            = level_q;
  assign over_budget      = over_q;
  assign window_energy_pj = win_energy_q;
  assign window_count     = win_count_q;

endmodule

// File: doc/energy_budget_dvfs_ctrl.md
Name: energy_budget_dvfs_ctrl

Overview:
Windowed energy-budget governor that sequences frequency changes for a compute tile. It samples the running total_energy_pj from the tile energy accumulator once per measurement window and compares the window delta against a programmed budget. It steps a frequency-level index down or up, and requests the new frequency from the clock generator over a req/ack handshake. Its current_freq_mhz output feeds back into the energy accumulator's frequency input.

Parameters:
NUM_LEVELS, 5, number of frequency levels; level 0 is slowest.
RESET_LEVEL, 4, level index after reset; must be less than NUM_LEVELS.
SETTLE_CYCLES, 16, cycles to wait after an ack before the next window starts.
LOW_SHIFT, 2, hysteresis: step up only if window energy < budget - (budget >> LOW_SHIFT).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  governor enable
window_cycles  in  32  window length in cycles; 0 is treated as 1
budget_pj  in  64  energy budget per window; sampled in EVAL
energy_total_pj  in  64  running total from the energy accumulator
freq_req  out  1  frequency change request to the clock generator
freq_req_mhz  out  16  requested frequency; stable while freq_req=1
freq_ack  in  1  clock generator acknowledge
current_freq_mhz  out  16  committed frequency
level  out  3  committed level index
over_budget  out  1  one-cycle pulse when a window exceeds budget
window_energy_pj  out  64  energy of the last completed window
window_count  out  32  completed windows; wraps modulo 2^32

Behaviour:
- Reset values:
  - state=IDLE, freq_req=0, freq_req_mhz=FREQ_TABLE[RESET_LEVEL].
  - level=RESET_LEVEL, current_freq_mhz=FREQ_TABLE[RESET_LEVEL].
  - over_budget=0, window_energy_pj=0, window_count=0, internal snapshot=0, cycle counter=0.
- IDLE:
  - If enable=1: snapshot <= energy_total_pj, counter <= 0, go to MEASURE.
- MEASURE:
  - Counter increments each cycle.
  - When counter == max(window_cycles,1)-1: go to EVAL. A window therefore occupies exactly max(window_cycles,1) cycles.
  - enable=0: go to IDLE the next cycle, no evaluation, outputs unchanged.
- EVAL (one cycle):
  - delta = energy_total_pj - snapshot, modulo 2^64 (a wrap of the total is handled naturally).
  - window_energy_pj <= delta; window_count += 1.
  - If delta > budget_pj: over_budget pulses; target = max(level-1, 0).
  - Else if delta < budget_pj - (budget_pj >> LOW_SHIFT): target = min(level+1, NUM_LEVELS-1).
  - Otherwise target = level.
  - If target != level: freq_req_mhz <= FREQ_TABLE[target], go to REQ.
  - If target == level, including saturated cases: snapshot <= energy_total_pj, counter <= 0, go to MEASURE (or IDLE if enable=0). No request is issued.
- REQ:
  - freq_req=1; freq_req_mhz is held stable until freq_ack is sampled high.
  - On the cycle freq_ack=1: freq_req <= 0, level <= target, current_freq_mhz <= FREQ_TABLE[target] (visible the next cycle), go to SETTLE.
  - enable=0 during REQ does not abort; the handshake completes first.
  - freq_ack outside REQ is ignored.
- SETTLE:
  - Wait SETTLE_CYCLES cycles.
  - Then: snapshot <= energy_total_pj, counter <= 0, go to MEASURE if enable=1, else IDLE.
- Reset mid-operation: asserting reset in any state (including REQ) immediately drops freq_req and restores all reset values.
- Arithmetic:
  - All energy compares are unsigned 64-bit.
  - The hysteresis threshold is computed with no underflow, since budget >> LOW_SHIFT <= budget.
  - budget_pj=0: any nonzero delta steps down; delta=0 holds.

Decomposition:
- Package power_pkg holds:
  - FREQ_TABLE constant: 200, 400, 600, 800, 1000 MHz for levels 0..4.
  - State enum: IDLE, MEASURE, EVAL, REQ, SETTLE.
  - Level width constant: 3.
- One natural sub-module: energy_window_sampler. It holds the snapshot register, window counter and delta subtraction, and outputs window_done and delta.

Test Plan:
1. Reset, enable=1, window_cycles=100, budget_pj=1000, energy_total_pj rising 20 pJ/cycle (delta 2000) -> EVAL after 100 cycles, over_budget pulse, freq_req=1 with freq_req_mhz=800. Ack after 3 cycles -> current_freq_mhz=800, level=3, window_count=1.
2. Level 0 and a repeated over-budget window -> no freq_req, level stays 0, over_budget still pulses, next window starts directly.
3. budget_pj=1000, delta=700 (< 750) at level 3 -> request 1000 MHz. Delta=800 -> hold, no request.
4. Snapshot 0xFFFF_FFFF_FFFF_FF00, total wraps to 0x0000_0000_0000_0100 -> window_energy_pj=0x200.
5. enable dropped mid-MEASURE -> IDLE, no request. enable dropped during REQ -> freq_req held until ack, then IDLE via SETTLE.
6. reset pulsed while freq_req=1 -> freq_req=0 on reset assertion, current_freq_mhz=1000, level=4. window_cycles=0 -> window length of 1 cycle.
